// File: rtl/easyaxi_pkg.sv
// Shared widths, burst/response encodings, FSM states and AW request layout for the easyaxi slaves.
package easyaxi_pkg;

   localparam int AXI_ID_W    = 4;
   localparam int AXI_ADDR_W  = 32;
   localparam int AXI_LEN_W   = 8;
   localparam int AXI_SIZE_W  = 3;
   localparam int AXI_BURST_W = 2;
   localparam int AXI_DATA_W  = 32;
   localparam int AXI_STRB_W  = AXI_DATA_W / 8;
   localparam int AXI_RESP_W  = 2;

   localparam logic [AXI_BURST_W-1:0] BURST_FIXED = 2'd0;
   localparam logic [AXI_BURST_W-1:0] BURST_INCR  = 2'd1;
   localparam logic [AXI_BURST_W-1:0] BURST_WRAP  = 2'd2;
   localparam logic [AXI_BURST_W-1:0] BURST_RSVD  = 2'd3;

   localparam logic [AXI_RESP_W-1:0] RESP_OKAY   = 2'b00;
   localparam logic [AXI_RESP_W-1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DATA = 2'd1,
      ST_RESP = 2'd2
   } wr_state_e;

   typedef struct packed {
      logic [AXI_ID_W-1:0]    id;
      logic [AXI_ADDR_W-1:0]  addr;
      logic [AXI_LEN_W-1:0]   len;
      logic [AXI_SIZE_W-1:0]  size;
      logic [AXI_BURST_W-1:0] burst;
   } aw_req_t;

   // WRAP only defines 2, 4, 8 or 16 beat bursts; anything else is flagged but still consumed.
   function automatic logic burst_illegal(input logic [AXI_BURST_W-1:0] burst,
                                          input logic [AXI_LEN_W-1:0]   len);
      burst_illegal = (burst == BURST_RSVD) ||
                      ((burst == BURST_WRAP) &&
                       !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15));
   endfunction

endpackage

// File: rtl/easyaxi_sync_fifo.sv
// Single-clock FIFO with registered occupancy count; holds outstanding AW requests.
module easyaxi_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_full,
   output logic             o_empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;

   // NOTE: storage is deliberately not reset; the count gates every use of it.
   always_ff @(posedge clk) begin
      if (i_push) r_mem[r_wr_ptr] <= i_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         if (i_push && !i_pop)      r_count <= r_count + CNT_W'(1);
         else if (i_pop && !i_push) r_count <= r_count - CNT_W'(1);
      end
   end

   assign o_data  = r_mem[r_rd_ptr];
   assign o_full  = (r_count == CNT_W'(DEPTH));
   assign o_empty = (r_count == '0);

endmodule

// File: rtl/easyaxi_wr_slv.sv
// AXI write-channel slave: queues AW, absorbs W bursts into a register memory, answers on B.
// Build option: define EASYAXI_WLAST_CHECK_EN to report wlast/awlen disagreement as SLVERR.
module easyaxi_wr_slv
   import easyaxi_pkg::*;
#(
   parameter int OST_DEPTH = 4,
   parameter int MEM_DEPTH = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         enable,
   input  logic                         axi_slv_awvalid,
   output logic                         axi_slv_awready,
   input  logic [AXI_ID_W-1:0]          axi_slv_awid,
   input  logic [AXI_ADDR_W-1:0]        axi_slv_awaddr,
   input  logic [AXI_LEN_W-1:0]         axi_slv_awlen,
   input  logic [AXI_SIZE_W-1:0]        axi_slv_awsize,
   input  logic [AXI_BURST_W-1:0]       axi_slv_awburst,
   input  logic                         axi_slv_wvalid,
   output logic                         axi_slv_wready,
   input  logic [AXI_DATA_W-1:0]        axi_slv_wdata,
   input  logic [AXI_STRB_W-1:0]        axi_slv_wstrb,
   input  logic                         axi_slv_wlast,
   output logic                         axi_slv_bvalid,
   input  logic                         axi_slv_bready,
   output logic [AXI_ID_W-1:0]          axi_slv_bid,
   output logic [AXI_RESP_W-1:0]        axi_slv_bresp,
   input  logic [$clog2(MEM_DEPTH)-1:0] mem_rd_addr,
   output logic [AXI_DATA_W-1:0]        mem_rd_data
);

   localparam int LSB   = $clog2(AXI_STRB_W);
   localparam int IDX_W = $clog2(MEM_DEPTH);
   localparam logic [AXI_ADDR_W-1:0] MEM_BYTES = AXI_ADDR_W'(MEM_DEPTH * AXI_STRB_W);

   wr_state_e             r_state, w_state_nxt;
   aw_req_t               w_aw_in, w_head, r_req;
   logic                  w_full, w_empty, w_push, w_pop, w_load, w_wbeat;
   logic                  w_last_beat, w_last_err, w_beat_err;
   logic [AXI_LEN_W-1:0]  r_beat_cnt;
   logic                  r_err;
   logic [AXI_DATA_W-1:0] r_mem [MEM_DEPTH];

   function automatic logic [AXI_ADDR_W-1:0] next_addr(input aw_req_t req);
      logic [AXI_ADDR_W-1:0] step, incr, mask;
      step = AXI_ADDR_W'(1) << req.size;
      incr = req.addr + step;
      mask = ((AXI_ADDR_W'(req.len) + AXI_ADDR_W'(1)) << req.size) - AXI_ADDR_W'(1);
      next_addr = incr;
      if (req.burst == BURST_FIXED)
         next_addr = req.addr;
      else if (req.burst == BURST_WRAP && !burst_illegal(req.burst, req.len))
         next_addr = (req.addr & ~mask) | (incr & mask);
   endfunction

   assign axi_slv_awready = enable & ~w_full & ~rst;
   assign w_push  = axi_slv_awvalid & axi_slv_awready;
   assign w_pop   = axi_slv_bvalid & axi_slv_bready;
   assign w_aw_in = '{id: axi_slv_awid, addr: axi_slv_awaddr, len: axi_slv_awlen,
                      size: axi_slv_awsize, burst: axi_slv_awburst};

   easyaxi_sync_fifo #(
      .WIDTH ($bits(aw_req_t)),
      .DEPTH (OST_DEPTH)
   ) u_aw_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_data  (w_aw_in),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   // NOTE: every output of this block gets a default first, so no latch can be inferred.
   always_comb begin
      w_state_nxt    = r_state;
      axi_slv_wready = 1'b0;
      axi_slv_bvalid = 1'b0;
      unique case (r_state)
         ST_IDLE: if (!w_empty) w_state_nxt = ST_DATA;
         ST_DATA: begin
            axi_slv_wready = enable;
            if (enable && axi_slv_wvalid && w_last_beat) w_state_nxt = ST_RESP;
         end
         ST_RESP: begin
            axi_slv_bvalid = 1'b1;
            if (axi_slv_bready) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign w_load      = (r_state == ST_IDLE) & ~w_empty;
   assign w_wbeat     = axi_slv_wvalid & axi_slv_wready;
   assign w_last_beat = (r_beat_cnt == r_req.len);

`ifdef EASYAXI_WLAST_CHECK_EN
   assign w_last_err = axi_slv_wlast ^ w_last_beat;
`else
   logic w_unused_wlast;
   assign w_unused_wlast = axi_slv_wlast;
   assign w_last_err     = 1'b0;
`endif
   assign w_beat_err = (r_req.addr >= MEM_BYTES) | w_last_err;

   // NOTE: this memory is reset on purpose -- an async reset must leave it all-zero at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_req      <= '0;
         r_beat_cnt <= '0;
         r_err      <= 1'b0;
         for (int i = 0; i < MEM_DEPTH; i++) r_mem[i] <= '0;
      end else if (w_load) begin
         r_req      <= w_head;
         r_beat_cnt <= '0;
         r_err      <= burst_illegal(w_head.burst, w_head.len);
      end else if (w_wbeat) begin
         r_err <= r_err | w_beat_err;
         if (r_req.addr < MEM_BYTES) begin
            for (int b = 0; b < AXI_STRB_W; b++)
               if (axi_slv_wstrb[b])
                  r_mem[r_req.addr[LSB +: IDX_W]][8*b +: 8] <= axi_slv_wdata[8*b +: 8];
         end
         if (!w_last_beat) begin
            r_beat_cnt <= r_beat_cnt + AXI_LEN_W'(1);
            r_req.addr <= next_addr(r_req);
         end
      end
   end

   assign axi_slv_bid   = r_req.id;
   assign axi_slv_bresp = r_err ? RESP_SLVERR : RESP_OKAY;
   assign mem_rd_data   = r_mem[mem_rd_addr];

endmodule
